pipe_ir_chain: RTL

Instruction-register chain and hazard interlock for the pipelined processor. It sits directly upstream of the execute-stage control decoder. It takes fetched instructions (IR1) and advances them through IR2 (decode/regfile read), IR3 (execute, decoded by the execute control) and IR4 (writeback). It detects RAW hazards, inserts NOP bubbles, freezes the chain on STOP, and counts stall cycles.

---
 rtl/pipe_ir_chain.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pipe_ir_chain.sv
// Instruction-register chain IR2..IR4 with RAW interlock, STOP freeze and a
// saturating stall-cycle counter. There is no forwarding, so IR3 and IR4 both interlock.
module pipe_ir_chain #(
  parameter logic [7:0]  NOP_INSTR = 8'h0A,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       ir1_in,
  input  logic             ir1_valid,
  input  logic             ir3_load,
  output logic             stall,
  output logic [7:0]       ir2,
  output logic [7:0]       ir3,
  output logic [7:0]       ir4,
  output logic             ir4_valid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  function automatic logic [3:0] reg_bit(input logic [1:0] r);
    return 4'b0001 << r;
  endfunction

  function automatic logic writes(input logic [3:0] op);
    return (op inside {4'h0, 4'h4, 4'h6, 4'h8}) || (op[2:0] == 3'd3) || (op[2:0] == 3'd7);
  endfunction

  function automatic logic [1:0] dest(input logic [7:0] x);
    return (x[2:0] == 3'd7) ? 2'b01 : x[7:6];
  endfunction

  // One bit per architectural register read by the instruction.
  function automatic logic [3:0] srcs(input logic [7:0] x);
    logic [3:0] m;
    m = 4'b0000;
    if (x[3:0] inside {4'h2, 4'h4, 4'h6, 4'h8}) begin
      m = reg_bit(x[7:6]) | reg_bit(x[5:4]);
    end else if (x[3:0] == 4'h0) begin
      m = reg_bit(x[5:4]);
    end else if (x[2:0] == 3'd3) begin
      m = reg_bit(x[7:6]);
    end else if (x[2:0] == 3'd7) begin
      m = 4'b0010;
    end
    return m;
  endfunction

  logic [7:0]       ir2_q, ir2_d, ir3_q, ir3_d, ir4_q, ir4_d;
  logic             v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       prod_mask;
  logic             hazard, halt_now;

  always_comb begin
    prod_mask = 4'b0000;
    if (v3_q && writes(ir3_q[3:0])) prod_mask = prod_mask | reg_bit(dest(ir3_q));
    if (v4_q && writes(ir4_q[3:0])) prod_mask = prod_mask | reg_bit(dest(ir4_q));
    hazard   = v2_q && ((srcs(ir2_q) & prod_mask) != 4'b0000);
    halt_now = v3_q && !ir3_load;
    stall    = hazard || halt_now || halted_q;
  end

  always_comb begin
    ir2_d    = ir2_q;
    ir3_d    = ir3_q;
    ir4_d    = ir4_q;
    v2_d     = v2_q;
    v3_d     = v3_q;
    v4_d     = v4_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (halt_now || halted_q) begin
      // Halt takes precedence over a coincident hazard; the counter stays put.
      ir4_d    = NOP_INSTR;
      v4_d     = 1'b0;
      halted_d = 1'b1;
    end else if (hazard) begin
      ir4_d = ir3_q;
      v4_d  = v3_q;
      ir3_d = NOP_INSTR;
      v3_d  = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ir4_d = ir3_q;
      v4_d  = v3_q;
      ir3_d = ir2_q;
      v3_d  = v2_q;
      ir2_d = ir1_valid ? ir1_in : NOP_INSTR;
      v2_d  = ir1_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ir2_q    <= NOP_INSTR;
      ir3_q    <= NOP_INSTR;
      ir4_q    <= NOP_INSTR;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      v4_q     <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ir2_q    <= ir2_d;
      ir3_q    <= ir3_d;
      ir4_q    <= ir4_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      v4_q     <= v4_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ir2         = ir2_q;
  assign ir3         = ir3_q;
  assign ir4         = ir4_q;
  assign ir4_valid   = v4_q;
  assign halted      = halted_q;
  assign stall_count = cnt_q;

endmodule
